mem_port_arbiter: RTL

//   Shares the single memory_automate port between two requesters: the instruction-fetch path (FETCH) and the
//   EU data path (EU, e.g. ALU result writeback).

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// slave = the arbiter's view, master = the surrounding fetch/EU/memory environment.
interface mem_port_arbiter_if;
  logic [15:0] cs;
  logic [15:0] ds;

  logic        fetch_req;
  logic [15:0] fetch_off;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [15:0] fetch_rdata;

  logic        eu_req;
  logic        eu_we;
  logic [15:0] eu_off;
  logic [15:0] eu_wdata;
  logic        eu_gnt;
  logic        eu_rvalid;
  logic [15:0] eu_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [1:0]  mem_selector;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        busy;

  modport slave (
    input  cs, ds,
    input  fetch_req, fetch_off,
    input  eu_req, eu_we, eu_off, eu_wdata,
    input  mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    output eu_gnt, eu_rvalid, eu_rdata,
    output mem_en, mem_we, mem_addr, mem_selector, mem_wdata,
    output busy
  );

  modport master (
    output cs, ds,
    output fetch_req, fetch_off,
    output eu_req, eu_we, eu_off, eu_wdata,
    output mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    input  eu_gnt, eu_rvalid, eu_rdata,
    input  mem_en, mem_we, mem_addr, mem_selector, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between FETCH and EU: EU-priority arbitration with FETCH anti-starvation.
// Grant in the request cycle, mem_en one cycle later, read data MEM_LAT+1 cycles after grant; one access in flight.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 3
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus_io
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

  state_e        state_q;
  logic [SW-1:0] starve_q;
  logic [CW-1:0] wait_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [19:0]   addr_q;
  logic [1:0]    sel_q;
  logic [15:0]   wdata_q;
  logic [15:0]   fetch_rdata_q;
  logic [15:0]   eu_rdata_q;

  logic          idle_ok_d;
  logic          fetch_win_d;
  logic          fetch_gnt_d;
  logic          eu_gnt_d;
  logic          resp_d;
  logic [19:0]   gnt_addr_d;

  // FETCH only beats a pending EU request once EU has starved it STARVE_LIM times.
  always_comb begin
    idle_ok_d   = (state_q == S_IDLE) && !reset;
    fetch_win_d = bus_io.fetch_req && (!bus_io.eu_req || starve_q == SW'(STARVE_LIM));
    fetch_gnt_d = idle_ok_d && fetch_win_d;
    eu_gnt_d    = idle_ok_d && bus_io.eu_req && !fetch_win_d;
    resp_d      = (state_q == S_RESP) && !reset;
    gnt_addr_d  = fetch_win_d ? ({bus_io.cs, 4'b0} + {4'b0, bus_io.fetch_off})
                              : ({bus_io.ds, 4'b0} + {4'b0, bus_io.eu_off});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      starve_q      <= '0;
      wait_q        <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      addr_q        <= '0;
      sel_q         <= '0;
      wdata_q       <= '0;
      fetch_rdata_q <= '0;
      eu_rdata_q    <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fetch_gnt_d || eu_gnt_d) begin
            state_q  <= S_ACCESS;
            mem_en_q <= 1'b1;
            mem_we_q <= eu_gnt_d && bus_io.eu_we;
            addr_q   <= gnt_addr_d;
            sel_q    <= eu_gnt_d ? 2'b01 : 2'b00;
            if (eu_gnt_d) begin
              wdata_q <= bus_io.eu_wdata;
            end
            if (eu_gnt_d && bus_io.fetch_req) begin
              starve_q <= (starve_q == SW'(STARVE_LIM)) ? starve_q : starve_q + SW'(1);
            end else begin
              starve_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (mem_we_q) begin
            state_q <= S_IDLE;
          end else if (MEM_LAT == 1) begin
            state_q <= S_RESP;
          end else begin
            state_q <= S_WAIT;
            wait_q  <= CW'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
          end
        end
        S_WAIT: begin
          if (wait_q == '0) begin
            state_q <= S_RESP;
          end else begin
            wait_q <= wait_q - CW'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          if (sel_q == 2'b01) begin
            eu_rdata_q <= bus_io.mem_rdata;
          end else begin
            fetch_rdata_q <= bus_io.mem_rdata;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data is forwarded straight from memory in the RESP cycle, then held.
  assign bus_io.fetch_gnt    = fetch_gnt_d;
  assign bus_io.eu_gnt       = eu_gnt_d;
  assign bus_io.fetch_rvalid = resp_d && (sel_q == 2'b00);
  assign bus_io.eu_rvalid    = resp_d && (sel_q == 2'b01);
  assign bus_io.fetch_rdata  = bus_io.fetch_rvalid ? bus_io.mem_rdata : fetch_rdata_q;
  assign bus_io.eu_rdata     = bus_io.eu_rvalid ? bus_io.mem_rdata : eu_rdata_q;
  assign bus_io.mem_en       = mem_en_q;
  assign bus_io.mem_we       = mem_we_q;
  assign bus_io.mem_addr     = addr_q;
  assign bus_io.mem_selector = sel_q;
  assign bus_io.mem_wdata    = wdata_q;
  assign bus_io.busy         = (state_q != S_IDLE);

endmodule
